// File: rtl/hash_out_mem_writer.sv
// hash_out_mem_writer: writes a digest word stream into RAM, zeroing the unused tail bits of the last word
module hash_out_mem_writer #(
  parameter int IO_WIDTH = 32,
  parameter int MAX_RAM_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [IO_WIDTH-1:0]              i_output_length,
  input  logic [$clog2(MAX_RAM_DEPTH)-1:0] i_base_addr,
  input  logic                             i_stall,
  input  logic [IO_WIDTH-1:0]              i_data_in,
  input  logic                             i_data_in_valid,
  output logic                             o_data_in_ready,
  output logic                             o_wr_en,
  output logic [$clog2(MAX_RAM_DEPTH)-1:0] o_addr,
  output logic [IO_WIDTH-1:0]              o_wr_data,
  output logic                             o_busy,
  output logic                             o_done
);
  localparam int AW = $clog2(MAX_RAM_DEPTH);
  localparam int LW = $clog2(IO_WIDTH);
  localparam int CW = IO_WIDTH - LW + 1;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state;
  logic [IO_WIDTH-1:0] len_q;
  logic [AW-1:0] base_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] n_words;
  logic [LW-1:0] rem;
  logic accept;
  logic last;
  logic [IO_WIDTH-1:0] keep_mask;
  // Word count, trailing-bit mask and the stream handshake
  always_comb begin
    rem = len_q[LW-1:0];
    n_words = {1'b0, len_q[IO_WIDTH-1:LW]} + CW'(|rem);
    o_data_in_ready = state == WRITE && !i_stall && !rst;
    accept = o_data_in_ready && i_data_in_valid;
    last = cnt + CW'(1) == n_words;
    keep_mask = last && |rem ? ~({IO_WIDTH{1'b1}} >> rem) : {IO_WIDTH{1'b1}};
  end
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  // Job FSM plus the one-cycle-latency RAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      base_q <= '0;
      cnt <= '0;
      o_wr_en <= 1'b0;
      o_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= accept;
      if (accept) begin
        o_addr <= base_q + cnt[AW-1:0];
        o_wr_data <= i_data_in & keep_mask;
        cnt <= cnt + CW'(1);
      end
      if (state == IDLE && i_start) begin
        len_q <= i_output_length;
        base_q <= i_base_addr;
        cnt <= '0;
        state <= i_output_length == '0 ? DONE : WRITE;
      end else if (state == WRITE && accept && last) state <= DONE;
      else if (state == DONE) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_hash_out_mem_writer.sv
// tb_hash_out_mem_writer: random and directed jobs checked every cycle against a behavioural model
module tb_hash_out_mem_writer;
  localparam int W = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 0, rst = 1, i_start = 0, i_stall = 0, i_data_in_valid = 0;
  logic [W-1:0] i_output_length = '0, i_data_in = '0;
  logic [AW-1:0] i_base_addr = '0;
  logic o_data_in_ready, o_wr_en, o_busy, o_done;
  logic [AW-1:0] o_addr;
  logic [W-1:0] o_wr_data;
  int n_vec = 0, n_bad = 0;
  bit chk = 0;
  int m_phase = 0, m_len = 0, m_base = 0, m_k = 0;
  logic e_wr_en = 0;
  logic [AW-1:0] e_addr = '0;
  logic [W-1:0] e_data = '0;
  logic [W-1:0] ram [DEPTH];
  int wrs = 0, dones = 0, busy_cyc = 0, rdy_cyc = 0;
  logic [W-1:0] stream [$];
  logic [W-1:0] sent [$];
  int w0, d0, b0, r0, w1;
  wire m_acc = m_phase == 1 && !i_stall && i_data_in_valid && !rst;

  always #5 clk = ~clk;

  hash_out_mem_writer #(.IO_WIDTH(W), .MAX_RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_output_length(i_output_length),
    .i_base_addr(i_base_addr), .i_stall(i_stall), .i_data_in(i_data_in),
    .i_data_in_valid(i_data_in_valid), .o_data_in_ready(o_data_in_ready),
    .o_wr_en(o_wr_en), .o_addr(o_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  function automatic int n_words(input int len);
    return (len + W - 1) / W;
  endfunction

  function automatic logic [W-1:0] exp_word(input logic [W-1:0] d, input int len, input int k);
    int r;
    r = len % W;
    return (k == n_words(len) - 1 && r != 0) ? (d >> (W - r)) << (W - r) : d;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  // Phases: 0 idle, 1 collecting words, 2 completion cycle
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_k <= 0;
      e_wr_en <= 1'b0;
      e_addr <= '0;
      e_data <= '0;
    end else begin
      e_wr_en <= m_acc;
      if (m_acc) begin
        e_addr <= AW'((m_base + m_k) % DEPTH);
        e_data <= exp_word(i_data_in, m_len, m_k);
        m_k <= m_k + 1;
      end
      if (m_phase == 0 && i_start) begin
        m_len <= int'(i_output_length);
        m_base <= int'(i_base_addr);
        m_k <= 0;
        m_phase <= i_output_length == 0 ? 2 : 1;
      end else if (m_phase == 1 && m_acc && m_k + 1 == n_words(m_len)) m_phase <= 2;
      else if (m_phase == 2) m_phase <= 0;
    end
  end

  // Compare every cycle and log what the DUT wrote
  always @(negedge clk) begin
    if (chk) begin
      cmp("ready", o_data_in_ready, m_phase == 1 && !i_stall && !rst);
      cmp("wr_en", o_wr_en, e_wr_en);
      cmp("addr", o_addr, e_addr);
      cmp("wr_data", o_wr_data, e_data);
      cmp("busy", o_busy, m_phase != 0);
      cmp("done", o_done, m_phase == 2);
      if (o_wr_en) begin
        ram[o_addr] <= o_wr_data;
        wrs <= wrs + 1;
      end
      if (o_done) dones <= dones + 1;
      if (o_busy) busy_cyc <= busy_cyc + 1;
      if (o_data_in_ready) rdy_cyc <= rdy_cyc + 1;
    end
  end

  task automatic run_job(input int len, input int base, input int vpct, input int spct, input bit noise);
    int cyc;
    bit a;
    cyc = 0;
    w0 = wrs;
    d0 = dones;
    b0 = busy_cyc;
    r0 = rdy_cyc;
    i_output_length = W'(len);
    i_base_addr = AW'(base);
    i_data_in_valid = 0;
    i_stall = 0;
    i_start = 1;
    @(posedge clk);
    #1 i_start = 0;
    while (m_phase != 0 && cyc < 2000) begin
      i_data_in_valid = $urandom_range(99) < vpct;
      i_stall = $urandom_range(99) < spct;
      i_data_in = stream.size() != 0 ? stream[0] : W'($urandom);
      if (noise && $urandom_range(9) == 0) begin
        i_start = 1;
        i_output_length = W'($urandom_range(600));
        i_base_addr = AW'($urandom);
      end
      #1 a = m_acc;
      @(posedge clk);
      #1 i_start = 0;
      if (a && stream.size() != 0) void'(stream.pop_front());
      cyc++;
    end
    if (cyc >= 2000) begin
      n_vec++;
      n_bad++;
      $display("FAIL job_timeout len=%0d: got no return to idle, expected completion", len);
    end
    i_data_in_valid = 0;
    i_stall = 0;
    stream.delete();
  endtask

  initial begin
    @(posedge clk);
    chk = 1;
    @(posedge clk);
    #1 rst = 0;
    stream = {32'hAABBCCDD, 32'h11223344};
    run_job(40, 0, 100, 0, 0);
    cmp("len40_word0", ram[0], 32'hAABBCCDD);
    cmp("len40_word1_masked", ram[1], 32'h11000000);
    cmp("len40_writes", wrs - w0, 2);
    cmp("len40_done", dones - d0, 1);
    sent.delete();
    for (int i = 0; i < 8; i++) sent.push_back(W'($urandom));
    stream = sent;
    run_job(256, 3, 100, 0, 0);
    cmp("len256_writes", wrs - w0, 8);
    cmp("len256_first", ram[3], sent[0]);
    cmp("len256_last", ram[10], sent[7]);
    cmp("len256_busy", busy_cyc - b0, 9);
    stream = {32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D};
    run_job(128, 14, 100, 0, 0);
    cmp("wrap_14", ram[14], 32'h0A0A0A0A);
    cmp("wrap_15", ram[15], 32'h0B0B0B0B);
    cmp("wrap_0", ram[0], 32'h0C0C0C0C);
    cmp("wrap_1", ram[1], 32'h0D0D0D0D);
    for (int i = 0; i < 4; i++) begin
      run_job(96, 5, 50, 40, 1);
      cmp("stall_writes", wrs - w0, 3);
      cmp("stall_done", dones - d0, 1);
    end
    run_job(0, 7, 100, 0, 0);
    cmp("zero_writes", wrs - w0, 0);
    cmp("zero_done", dones - d0, 1);
    cmp("zero_busy", busy_cyc - b0, 1);
    cmp("zero_ready", rdy_cyc - r0, 0);
    w0 = wrs;
    i_output_length = 256;
    i_base_addr = 2;
    i_start = 1;
    @(posedge clk);
    #1 i_start = 0;
    for (int c = 0; c < 50 && wrs - w0 < 4; c++) begin
      i_data_in_valid = 1;
      i_data_in = W'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    cmp("rst_wr_en", o_wr_en, 0);
    cmp("rst_busy", o_busy, 0);
    cmp("rst_done", o_done, 0);
    cmp("rst_addr", o_addr, 0);
    cmp("rst_data", o_wr_data, 0);
    cmp("rst_ready", o_data_in_ready, 0);
    w1 = wrs;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 cmp("no_wr_after_rst", wrs, w1);
    i_data_in_valid = 0;
    @(posedge clk);
    #1 run_job(64, 9, 100, 0, 0);
    cmp("post_rst_writes", wrs - w0, 2);
    cmp("post_rst_done", dones - d0, 1);
    for (int j = 0; j < 40; j++) begin
      int len;
      len = $urandom_range(3) == 0 ? 0 : $urandom_range(1, 600);
      run_job(len, $urandom_range(DEPTH - 1), $urandom_range(30, 100), $urandom_range(50), 1);
      cmp("rand_writes", wrs - w0, n_words(len));
      cmp("rand_done", dones - d0, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/hash_out_mem_writer.md
HASH_OUT_MEM_WRITER -- requirements
Module: hash_out_mem_writer

Interface
REQ-001 SHALL have parameter IO_WIDTH, default 32, meaning stream and RAM word width in bits (multiple of 8).
REQ-002 SHALL have parameter MAX_RAM_DEPTH, default 16, meaning destination RAM depth in words; AW = clog2(MAX_RAM_DEPTH).
REQ-003 SHALL have ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  start pulse; sampled only in IDLE
- i_output_length  in  IO_WIDTH  digest length in bits; latched on accepted start
- i_base_addr  in  AW  first RAM word address; latched on accepted start
- i_stall  in  1  consumer hold; blocks acceptance while high
- i_data_in  in  IO_WIDTH  digest word from the SHAKE memory interface
- i_data_in_valid  in  1  digest word valid
- o_data_in_ready  out  1  block accepts the word this cycle
- o_wr_en  out  1  RAM write strobe
- o_addr  out  AW  RAM write address
- o_wr_data  out  IO_WIDTH  RAM write data
- o_busy  out  1  high from start acceptance until return to IDLE
- o_done  out  1  one-cycle completion pulse

Function
REQ-004 SHALL implement FSM states IDLE, WRITE and DONE.
REQ-005 IDLE: when i_start=1, latch the length and base, clear the word counter, and go to WRITE; if the length is 0, go to DONE instead.
REQ-006 Number of words SHALL be N = ceil(len/IO_WIDTH), computed as len[IO_WIDTH-1:clog2(IO_WIDTH)] + (|len[clog2(IO_WIDTH)-1:0]).
REQ-007 o_data_in_ready SHALL equal (state==WRITE) && !i_stall; it SHALL be combinational and SHALL NOT depend on i_data_in_valid.
REQ-008 A word is accepted in a cycle where i_data_in_valid && o_data_in_ready; no other cycle consumes data.
REQ-009 For the k-th accepted word (k = 0..N-1), in the next cycle the block SHALL drive o_wr_en=1, o_addr=(base+k) mod 2^AW and o_wr_data=masked word; write latency is 1 cycle.
REQ-010 In any cycle following a non-accepting cycle, o_wr_en SHALL be 0; o_addr and o_wr_data hold their last values.
REQ-011 Masking: when k=N-1 and r = len mod IO_WIDTH is nonzero, only the r most-significant bits SHALL pass; the lower IO_WIDTH-r bits SHALL be 0. All other words pass unmodified.
REQ-012 On acceptance of word N-1, go to DONE; o_data_in_ready SHALL be 0 in DONE, so surplus stream words are not consumed.
REQ-013 DONE SHALL last exactly one cycle with o_done=1, coinciding with the final write strobe, then return to IDLE.
REQ-014 For a zero-length job, o_done SHALL pulse in the cycle after start with no write strobe.
REQ-015 o_busy SHALL be 1 in WRITE and DONE, and 0 in IDLE.
REQ-016 i_start in WRITE or DONE SHALL be ignored; the latched length and base SHALL NOT change.
REQ-017 Address arithmetic SHALL wrap modulo 2^AW with no error indication.
REQ-018 The word counter SHALL be IO_WIDTH-clog2(IO_WIDTH)+1 bits wide so that it never overflows for any length.
REQ-019 i_stall rising mid-job SHALL only pause acceptance; the counter, address and state are preserved.

Reset
REQ-020 When rst=1 at a clock edge: state=IDLE, o_wr_en=0, o_done=0, o_busy=0, o_addr=0, o_wr_data=0, counter=0.
REQ-021 rst SHALL take priority over all other inputs, including mid-job; the partial job is abandoned and no further writes occur.
REQ-022 o_data_in_ready SHALL be 0 during reset and in the first cycle after it.

Verification
REQ-023 len=256, base=3, 8 words with valid held high, no stall -> writes to addresses 3..10 on consecutive cycles, data unmasked, o_done pulses with the write to 10.
REQ-024 len=40, base=0, words 0xAABBCCDD and 0x11223344 -> writes at addr 0 = 0xAABBCCDD and addr 1 = 0x11000000; o_done pulses with the second write.
REQ-025 len=128, base=14, MAX_RAM_DEPTH=16 -> writes at addresses 14, 15, 0, 1 (wrap).
REQ-026 len=96, i_stall high for 3 cycles after the first accept, valid toggling -> exactly 3 writes at base..base+2, data in arrival order, no duplicates.
REQ-027 len=0 -> o_busy high for 1 cycle, o_done pulses the cycle after start, o_wr_en never asserts, o_data_in_ready never asserts.
REQ-028 len=256, rst asserted after 4 writes -> all outputs are 0 the next cycle, no further writes; a new start after reset completes normally.
